// File: rtl/poly_square_mixer_if.sv
// poly_square_mixer_if
//   Bundle between the tone/period generators, the mixer core and the I2S side.
//   master : drives per-voice settings and sample_req, observes the mixed sample.
//   slave  : the mixer core.
//   Signals:
//     period, duty   VOICES*PERIOD_W  per-voice period / high time (voice i at [i*PERIOD_W +: PERIOD_W])
//     amp            VOICES*AMP_W     per-voice unsigned amplitude
//     voice_en       VOICES           per-voice enable
//     sample_req     1                request one mixed sample
//     sample         SAMPLE_W         signed mixed sample, held between updates
//     sample_valid   1                one-cycle pulse on sample update
//     sample_overrun 1                one-cycle pulse after a dropped request
//     voice_level    VOICES           live square level per oscillator
interface poly_square_mixer_if #(
  parameter int VOICES   = 4,
  parameter int PERIOD_W = 16,
  parameter int AMP_W    = 8,
  parameter int SAMPLE_W = 16
);
  logic [VOICES*PERIOD_W-1:0] period;
  logic [VOICES*PERIOD_W-1:0] duty;
  logic [VOICES*AMP_W-1:0]    amp;
  logic [VOICES-1:0]          voice_en;
  logic                       sample_req;
  logic [SAMPLE_W-1:0]        sample;
  logic                       sample_valid;
  logic                       sample_overrun;
  logic [VOICES-1:0]          voice_level;

  modport master (
    output period, duty, amp, voice_en, sample_req,
    input  sample, sample_valid, sample_overrun, voice_level
  );

  modport slave (
    input  period, duty, amp, voice_en, sample_req,
    output sample, sample_valid, sample_overrun, voice_level
  );
endinterface

// File: rtl/poly_square_mixer.sv
// poly_square_mixer
//   VOICES free-running square oscillators mixed on request into one signed
//   sample by a time-multiplexed accumulator (one voice per cycle).
//   Ports:
//     clk    audio clock, rising edge
//     reset  synchronous, active-low
//     bus    poly_square_mixer_if.slave (settings in, sample/flags/levels out)

// One oscillator lane: phase counter plus level compare.
module psm_voice #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [PERIOD_W-1:0] i_duty,
  output logic                o_level,
  output logic                o_silent
);
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic                r_run;

  assign o_silent = (i_period < PERIOD_W'(2));

  // Wrap on >= rather than == so a period shrinking below the current
  // phase restarts immediately instead of running up to 2^PERIOD_W.
  always_comb begin
    w_cnt_nxt = r_cnt + PERIOD_W'(1);
    if (o_silent || (r_cnt >= i_period - PERIOD_W'(1))) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_run <= 1'b1;
    end
  end

  // r_run keeps the level low while reset is held.
  assign o_level = r_run && !o_silent && (r_cnt < i_duty);
endmodule

module poly_square_mixer #(
  parameter int VOICES   = 4,
  parameter int PERIOD_W = 16,
  parameter int AMP_W    = 8,
  parameter int SAMPLE_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  poly_square_mixer_if.slave   bus
);
  localparam int LOG_V = $clog2(VOICES);
  localparam int ACC_W = AMP_W + 1 + LOG_V;
  localparam int IDX_W = (LOG_V > 0) ? LOG_V : 1;
  localparam int SHIFT = SAMPLE_W - ACC_W;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  logic [VOICES-1:0][PERIOD_W-1:0] w_period;
  logic [VOICES-1:0][PERIOD_W-1:0] w_duty;
  logic [VOICES-1:0][AMP_W-1:0]    w_amp;
  logic [VOICES-1:0]               w_level;
  logic [VOICES-1:0]               w_silent;

  assign w_period = bus.period;
  assign w_duty   = bus.duty;
  assign w_amp    = bus.amp;

  // Oscillators run regardless of enable or mixer state.
  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    psm_voice #(.PERIOD_W(PERIOD_W)) u_voice (
      .clk      (clk),
      .reset    (reset),
      .i_period (w_period[g]),
      .i_duty   (w_duty[g]),
      .o_level  (w_level[g]),
      .o_silent (w_silent[g])
    );
  end

  state_t r_state, w_state_nxt;
  logic   w_start, w_drop, w_last;

  logic [VOICES-1:0]               r_snap_lvl;
  logic [VOICES-1:0]               r_snap_en;
  logic [VOICES-1:0]               r_snap_sil;
  logic [VOICES-1:0][AMP_W-1:0]    r_snap_amp;
  logic [IDX_W-1:0]                r_idx;
  logic signed [ACC_W-1:0]         r_acc;
  logic signed [ACC_W-1:0]         w_mag;
  logic signed [ACC_W-1:0]         w_contrib;
  logic signed [ACC_W-1:0]         w_sum;
  logic signed [SAMPLE_W-1:0]      w_sample_nxt;
  logic [SAMPLE_W-1:0]             r_sample;
  logic                            r_valid;
  logic                            r_ovr;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_drop      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sample_req) begin
          w_start     = 1'b1;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_drop = bus.sample_req;
        if (r_idx == IDX_W'(VOICES - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Contribution of the voice selected by r_idx, from the snapshot only.
  always_comb begin
    w_mag     = ACC_W'(r_snap_amp[r_idx]);
    w_contrib = '0;
    if (r_snap_en[r_idx] && !r_snap_sil[r_idx])
      w_contrib = r_snap_lvl[r_idx] ? w_mag : -w_mag;
  end

  assign w_sum = r_acc + w_contrib;
  // Sign-extend then left-justify into the output word; full scale always fits.
  assign w_sample_nxt = SAMPLE_W'(w_sum) <<< SHIFT;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_snap_lvl <= '0;
      r_snap_en  <= '0;
      r_snap_sil <= '0;
      r_snap_amp <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_valid <= w_last;
      r_ovr   <= w_drop;
      if (w_start) begin
        r_snap_lvl <= w_level;
        r_snap_en  <= bus.voice_en;
        r_snap_sil <= w_silent;
        r_snap_amp <= w_amp;
        r_idx      <= '0;
        r_acc      <= '0;
      end else if (r_state == S_ACCUM) begin
        r_acc <= w_sum;
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_last) r_sample <= w_sample_nxt;
    end
  end

  assign bus.sample         = r_sample;
  assign bus.sample_valid   = r_valid;
  assign bus.sample_overrun = r_ovr;
  assign bus.voice_level    = w_level;
endmodule

// File: tb/tb_poly_square_mixer.sv
// tb_poly_square_mixer
//   Directed stimulus with a cycle-accurate reference of the oscillators and the
//   request/accept rules; expected samples are queued at acceptance and
//   checked on the cycle they are due.
module tb_poly_square_mixer;
  localparam int VOICES = 4;
  localparam int PW     = 16;
  localparam int AW     = 8;
  localparam int SW     = 16;
  localparam int ACC_W  = AW + 1 + $clog2(VOICES);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  poly_square_mixer_if #(.VOICES(VOICES), .PERIOD_W(PW), .AMP_W(AW), .SAMPLE_W(SW)) bus ();

  poly_square_mixer #(.VOICES(VOICES), .PERIOD_W(PW), .AMP_W(AW), .SAMPLE_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_cnt [VOICES];
  bit m_run = 1'b0;
  int m_busy = 0;
  logic [SW-1:0] m_hold = '0;
  logic [SW-1:0] sq_val [$];
  int            sq_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [VOICES-1:0] exp_lvl();
    logic [VOICES-1:0] l;
    for (int i = 0; i < VOICES; i++) begin
      int per, dty;
      per  = int'(bus.period[i*PW +: PW]);
      dty  = int'(bus.duty[i*PW +: PW]);
      l[i] = m_run && (per >= 2) && (m_cnt[i] < dty);
    end
    return l;
  endfunction

  function automatic logic [SW-1:0] exp_mix();
    logic [VOICES-1:0] l;
    int s;
    s = 0;
    l = exp_lvl();
    for (int i = 0; i < VOICES; i++) begin
      int per, a;
      per = int'(bus.period[i*PW +: PW]);
      a   = int'(bus.amp[i*AW +: AW]);
      if (bus.voice_en[i] && per >= 2) s += l[i] ? a : -a;
    end
    return SW'(s * (2 ** (SW - ACC_W)));
  endfunction

  // One clock: advance the reference at the edge, then check 1 time unit later.
  task automatic tick();
    bit   rs, rq, busy_now, ev, ovr;
    @(posedge clk);
    rs  = reset;
    rq  = bus.sample_req;
    ovr = 1'b0;
    if (!rs) begin
      m_busy = 0;
      m_run  = 1'b0;
      for (int i = 0; i < VOICES; i++) m_cnt[i] = 0;
      sq_val.delete();
      sq_cyc.delete();
      m_hold = '0;
    end else begin
      busy_now = (m_busy > 0);
      if (m_busy > 0) m_busy--;
      if (rq) begin
        if (!busy_now) begin
          sq_val.push_back(exp_mix());
          sq_cyc.push_back(cyc + VOICES + 1);
          m_busy = VOICES;
        end else ovr = 1'b1;
      end
      for (int i = 0; i < VOICES; i++) begin
        int per;
        per = int'(bus.period[i*PW +: PW]);
        if (per < 2 || m_cnt[i] >= per - 1) m_cnt[i] = 0;
        else m_cnt[i] = m_cnt[i] + 1;
      end
      m_run = 1'b1;
    end
    cyc++;
    #1;
    ev = (sq_cyc.size() > 0) && (sq_cyc[0] == cyc);
    chk("sample_valid", 32'(bus.sample_valid), 32'(ev));
    if (ev) begin
      m_hold = sq_val.pop_front();
      void'(sq_cyc.pop_front());
    end
    chk(ev ? "sample_new" : "sample_hold", 32'(bus.sample), 32'(m_hold));
    chk("sample_overrun", 32'(bus.sample_overrun), 32'(ovr));
    chk("voice_level", 32'(bus.voice_level), 32'(exp_lvl()));
  endtask

  task automatic set_voice(input int i, input int per, input int dty, input int a, input bit en);
    bus.period[i*PW +: PW] = PW'(per);
    bus.duty[i*PW +: PW]   = PW'(dty);
    bus.amp[i*AW +: AW]    = AW'(a);
    bus.voice_en[i]        = en;
  endtask

  task automatic pulse(input int gap);
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    reset          = 1'b0;
    bus.period     = '0;
    bus.duty       = '0;
    bus.amp        = '0;
    bus.voice_en   = '0;
    bus.sample_req = 1'b0;
    repeat (3) tick();

    // Single voice, period 8 / duty 4; three requests 6 cycles apart hit both phases.
    reset = 1'b1;
    set_voice(0, 8, 4, 255, 1'b1);
    repeat (12) tick();
    pulse(5);
    pulse(5);
    pulse(5);

    // All voices constant high, then constant low.
    for (int i = 0; i < VOICES; i++) set_voice(i, 10, 10, 255, 1'b1);
    repeat (2) tick();
    pulse(6);
    for (int i = 0; i < VOICES; i++) set_voice(i, 10, 0, 255, 1'b1);
    repeat (2) tick();
    pulse(6);

    // Degenerate periods are silent even when enabled.
    for (int i = 1; i < VOICES; i++) set_voice(i, 0, 0, 0, 1'b0);
    set_voice(0, 1, 1, 200, 1'b1);
    repeat (3) tick();
    pulse(6);
    set_voice(0, 0, 1, 200, 1'b1);
    repeat (3) tick();
    pulse(6);

    // Period shrinks from 100 to 10 while the phase is at 50.
    set_voice(0, 100, 50, 10, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 200 && m_cnt[0] != 50; k++) tick();
    set_voice(0, 10, 5, 10, 1'b1);
    repeat (25) tick();

    // Mixed voices; requests in cycles 0, 2 and 5, amp changed after the snapshot.
    set_voice(0, 8, 4, 255, 1'b1);
    set_voice(1, 6, 2, 100, 1'b1);
    set_voice(2, 12, 9, 37, 1'b1);
    set_voice(3, 5, 3, 90, 1'b0);
    repeat (3) tick();
    bus.sample_req = 1'b1; tick();
    bus.sample_req = 1'b0; set_voice(1, 6, 2, 7, 1'b1); tick();
    bus.sample_req = 1'b1; tick();
    bus.sample_req = 1'b0; tick();
    tick();
    bus.sample_req = 1'b1; tick();
    bus.sample_req = 1'b0;
    repeat (7) tick();

    // Held-high request: back-to-back conversions with overruns in between.
    bus.sample_req = 1'b1;
    repeat (13) tick();
    bus.sample_req = 1'b0;
    repeat (8) tick();

    // Reset during the second ACCUM cycle aborts the conversion.
    bus.sample_req = 1'b1; tick();
    bus.sample_req = 1'b0; tick();
    reset = 1'b0; tick();
    reset = 1'b1;
    repeat (8) tick();
    pulse(7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/poly_square_mixer.md
Name: poly_square_mixer

Overview:
- Parameterised multi-voice square-wave synthesiser core, the successor to the single-voice square generator and amplifier path.
- Runs VOICES independent square oscillators, each with its own period, duty, enable and amplitude.
- On each request from the I2S side, mixes all voices into one signed bipolar sample using a time-multiplexed accumulator (one voice per cycle).
- Sits between the tone/period generators and i2s_controller; all logic runs on the audio (slow) clock.

Parameters:
- VOICES, 4, number of oscillators; must be ≥1 and a power of two.
- PERIOD_W, 16, width of each period and duty field (clock cycles).
- AMP_W, 8, width of each unsigned amplitude field.
- SAMPLE_W, 16, output sample width; must be ≥ AMP_W+1+log2(VOICES).

Ports:
- clk  in  1  audio clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- period  in  VOICES*PERIOD_W  per-voice period; voice i uses bits [i*PERIOD_W +: PERIOD_W].
- duty  in  VOICES*PERIOD_W  per-voice high time, same packing as period.
- amp  in  VOICES*AMP_W  per-voice unsigned amplitude.
- voice_en  in  VOICES  per-voice enable.
- sample_req  in  1  request a new mixed sample (typically one pulse per frame).
- sample  out  SAMPLE_W  signed two's-complement mixed sample; held between updates.
- sample_valid  out  1  one-cycle pulse when sample updates.
- sample_overrun  out  1  one-cycle pulse when a request is dropped.
- voice_level  out  VOICES  current square level of each oscillator (debug/GPIO).

Behaviour:
- Reset (reset==0 at a clock edge): all phase counters=0, voice_level=0, sample=0, sample_valid=0, sample_overrun=0, state=IDLE, accumulator=0.
- Oscillator i (free-running, independent of mixer state):
  - If period_i < 2: counter held at 0, level=0, voice is silent.
  - Otherwise: counter wraps to 0 when counter ≥ period_i-1, else increments by 1. This handles a period shrinking mid-cycle with no overshoot.
  - level = (counter < duty_i). duty=0 gives constant low; duty ≥ period gives constant high.
  - voice_en does not stop the counter.
- Contribution of voice i:
  - 0 if voice_en[i]==0 or period_i < 2.
  - +amp_i if level==1.
  - -amp_i if level==0.
  - Sign-extended to the accumulator width ACC_W = AMP_W+1+log2(VOICES).
- Mixer FSM:
  - IDLE:
    - sample_req==1: snapshot all levels, enables, amplitudes and silent flags into registers; idx=0; acc=0; go to ACCUM.
    - Otherwise stay in IDLE.
  - ACCUM:
    - Each cycle: acc += contribution(idx) from the snapshot; idx++.
    - When idx==VOICES-1: register sample = final sum sign-extended and shifted left by SAMPLE_W-ACC_W, set sample_valid=1, go to IDLE.
  - Full-scale ±(VOICES*(2^AMP_W-1)) always fits in SAMPLE_W; no saturation logic.
- Latency:
  - sample_req high in cycle 0 gives ACCUM in cycles 1..VOICES.
  - sample_valid is high in cycle VOICES+1 for exactly one cycle.
- Request rules:
  - sample_req while in ACCUM is dropped: sample_overrun pulses for one cycle, in the cycle after the dropped request.
  - A request in the same cycle sample_valid is high is accepted (FSM is in IDLE).
  - A held-high sample_req produces back-to-back conversions every VOICES+1 cycles and overrun pulses for the intermediate cycles.
- Input changes after the snapshot do not affect the sample in flight.
- Reset asserted mid-ACCUM: the conversion is aborted with no sample_valid; outputs take their reset values.

Test Plan:
- Reset then VOICES=4, voice0 period=8 duty=4 amp=255 en=1, others disabled → voice_level[0] is high 4 cycles, low 4 cycles; on each req, sample=+255<<5=8160 or -8160 matching the snapshot level; valid exactly 5 cycles after req.
- All 4 voices enabled, period=10, duty=10 (constant high), amp=255 → sample=32640; duty=0 → sample=-32640.
- Voice period=1 or 0 with en=1, amp=200, other voices off → sample=0 and voice_level=0.
- Period changed from 100 to 10 while counter=50 → counter wraps to 0 next cycle, then runs a 10-cycle period.
- sample_req pulsed at cycle 0 and cycle 2 → one sample_valid at cycle 5; sample_overrun high at cycle 3 only. Req at cycle 5 → accepted, valid at cycle 10.
- reset driven low at cycle 2 of ACCUM → no sample_valid; sample=0 afterwards. Next req after reset release produces a correct sample.
